// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite encodings, register map and FSM states
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [11:0] OFF_STATUS = 12'h01C;
    localparam logic [11:0] OFF_LIMIT  = 12'h020;
    localparam logic [2:0]  REG_STATUS = 3'd7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    function automatic logic trans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // Any write touching the STATUS word (any byte lane) is rejected.
    function automatic logic xfer_error(input logic [11:0] addr, input logic [2:0] size,
                                        input logic write);
        logic misaligned;
        misaligned = ((size == HSIZE_HALF) && addr[0]) ||
                     ((size == HSIZE_WORD) && (addr[1:0] != 2'b00));
        return (addr >= OFF_LIMIT) || (size > HSIZE_WORD) || misaligned ||
               (write && ((addr & ~12'h003) == OFF_STATUS));
    endfunction

endpackage

// File: rtl/ahb_lite_bytelane.sv
// rtl/ahb_lite_bytelane.sv - big-endian byte-lane merge of write data into a register word
module ahb_lite_bytelane
    import ahb_lite_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = i_old;
        case (i_size)
            HSIZE_BYTE: begin
                case (i_addr_lo)
                    2'd0:    o_word[31:24] = i_wdata[31:24];
                    2'd1:    o_word[23:16] = i_wdata[23:16];
                    2'd2:    o_word[15:8]  = i_wdata[15:8];
                    default: o_word[7:0]   = i_wdata[7:0];
                endcase
            end
            HSIZE_HALF: begin
                if (i_addr_lo[1]) o_word[15:0]  = i_wdata[15:0];
                else              o_word[31:16] = i_wdata[31:16];
            end
            HSIZE_WORD: o_word = i_wdata;
            default:    o_word = i_old;
        endcase
    end

endmodule

// File: rtl/ahb_lite_regs.sv
// rtl/ahb_lite_regs.sv - AHB-Lite slave with seven R/W registers and a STATUS counter word
module ahb_lite_regs
    import ahb_lite_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] reg_out
);

    localparam logic       LP_HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [1:0] LP_WAIT_LAST = 2'(WAIT_STATES - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_wait_cnt;
    logic [2:0]  r_word;
    logic [1:0]  r_lane;
    logic [2:0]  r_size;
    logic        r_write;
    logic [31:0] r_regs [0:6];
    logic [15:0] r_xfer_cnt;
    logic [15:0] r_err_cnt;

    logic        w_accept;
    logic        w_capture;
    logic        w_err;
    logic [2:0]  w_next;
    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic        w_unused_ok;

    assign w_unused_ok = &{1'b0, HADDR[31:12], HBURST, HPROT, HMASTLOCK};

    // New address phases are only taken in states that show HREADYOUT=1.
    assign w_accept  = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_capture = w_accept && HSEL && HREADY && trans_active(HTRANS);
    assign w_err     = xfer_error(HADDR[11:0], HSIZE, HWRITE);

    assign w_rdata = (r_word == REG_STATUS) ? {r_err_cnt, r_xfer_cnt} : r_regs[r_word];

    ahb_lite_bytelane u_bytelane (
        .i_size    (r_size),
        .i_addr_lo (r_lane),
        .i_wdata   (HWDATA),
        .i_old     (w_rdata),
        .o_word    (w_merged)
    );

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_WAIT: w_next = (r_wait_cnt == LP_WAIT_LAST) ? ST_DATA : ST_WAIT;
            ST_ERR1: w_next = ST_ERR2;
            default: begin
                if (w_capture) begin
                    if (w_err)            w_next = ST_ERR1;
                    else if (LP_HAS_WAIT) w_next = ST_WAIT;
                    else                  w_next = ST_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 2'd0;
            r_word     <= 3'd0;
            r_lane     <= 2'd0;
            r_size     <= 3'd0;
            r_write    <= 1'b0;
            r_xfer_cnt <= 16'd0;
            r_err_cnt  <= 16'd0;
            for (int i = 0; i < 7; i++) r_regs[i] <= RESET_VAL;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
            if (w_capture) begin
                r_word  <= HADDR[4:2];
                r_lane  <= HADDR[1:0];
                r_size  <= HSIZE;
                r_write <= HWRITE;
            end
            // Commit uses the pre-capture offset, so a chained transfer cannot disturb it.
            if ((r_state == ST_DATA) && r_write && (r_word != REG_STATUS))
                r_regs[r_word] <= w_merged;
            if (r_state == ST_DATA) r_xfer_cnt <= r_xfer_cnt + 16'd1;
            if (r_state == ST_ERR2) r_err_cnt  <= r_err_cnt + 16'd1;
        end
    end

    assign HREADYOUT = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign HRESP     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
    assign HRDATA    = (r_state == ST_DATA) ? w_rdata : 32'h0;
    assign reg_out   = r_regs[0];

endmodule

// File: tb/tb_ahb_lite_regs.sv
// tb/tb_ahb_lite_regs.sv - randomized self-checking bench for ahb_lite_regs
module tb_ahb_lite_regs;

    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV2 = 32'hDEAD_BEEF;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESETn, hsel0, hsel2, HWRITE, HMASTLOCK;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        rdy0, rdy2, resp0, resp2;
    logic [31:0] rdata0, rdata2, rout0, rout2;
    logic        sel;
    logic        hready_bus, hresp_bus;
    logic [31:0] hrdata_bus;

    assign hready_bus = sel ? rdy2   : rdy0;
    assign hresp_bus  = sel ? resp2  : resp0;
    assign hrdata_bus = sel ? rdata2 : rdata0;

    ahb_lite_regs #(.WAIT_STATES(0), .RESET_VAL(RV0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(hready_bus),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0), .reg_out(rout0)
    );

    ahb_lite_regs #(.WAIT_STATES(2), .RESET_VAL(RV2)) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(hready_bus),
        .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2), .reg_out(rout2)
    );

    typedef struct {
        logic [11:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        seq;
    } xfer_t;

    xfer_t       xq[$];
    int          n_vec, n_bad;
    logic [31:0] m_regs [2][7];
    logic [15:0] m_xfer [2];
    logic [15:0] m_err  [2];
    int          m_ws   [2] = '{0, 2};
    logic [31:0] m_rv   [2] = '{RV0, RV2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 7; k++) m_regs[d][k] = m_rv[d];
            m_xfer[d] = 16'd0;
            m_err[d]  = 16'd0;
        end
    endtask

    function automatic logic model_err(input logic [11:0] a, input logic [2:0] s, input logic w);
        int ai = int'(a);
        return (ai >= 32) || (s > 3'd2) || (s == 3'd1 && ai % 2 != 0) ||
               (s == 3'd2 && ai % 4 != 0) || (w && ai / 4 == 7);
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [11:0] a);
        int k = int'(a) / 4;
        if (k == 7) return {m_err[d], m_xfer[d]};
        return m_regs[d][k];
    endfunction

    task automatic model_write(input int d, input logic [11:0] a, input logic [2:0] s,
                               input logic [31:0] wd);
        int k  = int'(a) / 4;
        int lo = int'(a) % 4;
        logic [31:0] mask;
        if (s == 3'd0)      mask = 32'hFF << ((3 - lo) * 8);
        else if (s == 3'd1) mask = 32'hFFFF << ((2 - lo) * 8);
        else                mask = 32'hFFFF_FFFF;
        m_regs[d][k] = (m_regs[d][k] & ~mask) | (wd & mask);
    endtask

    task automatic push(input logic [11:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] wd, input logic sq);
        xfer_t x;
        x.addr = a; x.write = w; x.size = s; x.wdata = wd; x.seq = sq;
        xq.push_back(x);
    endtask

    task automatic drive_addr(input int d, input int i);
        HBURST    = 3'($urandom());
        HPROT     = 4'($urandom());
        HMASTLOCK = 1'($urandom());
        if (i < xq.size()) begin
            hsel0  = (d == 0);
            hsel2  = (d == 1);
            HTRANS = xq[i].seq ? 2'b11 : 2'b10;
            HADDR  = {20'($urandom()), xq[i].addr};
            HWRITE = xq[i].write;
            HSIZE  = xq[i].size;
        end else begin
            hsel0  = 1'($urandom());
            hsel2  = 1'($urandom());
            HTRANS = 2'($urandom_range(0, 1));
            HADDR  = $urandom();
            HWRITE = 1'($urandom());
            HSIZE  = 3'($urandom());
        end
    endtask

    task automatic complete(input int d, input int i, input int stall, input logic stall_resp);
        xfer_t x = xq[i];
        logic  err = model_err(x.addr, x.size, x.write);
        string t = $sformatf("d%0d a%03h w%0d s%0d", d, x.addr, x.write, x.size);
        check({t, " stall"}, 32'(stall), err ? 32'd1 : 32'(m_ws[d]));
        check({t, " resp"}, {31'd0, hresp_bus}, {31'd0, err});
        check({t, " stall_resp"}, {31'd0, stall_resp}, {31'd0, err});
        check({t, " reg_out"}, (d == 1) ? rout2 : rout0, m_regs[d][0]);
        if (err) begin
            check({t, " rdata"}, hrdata_bus, 32'h0);
            m_err[d]++;
        end else begin
            if (!x.write) check({t, " rdata"}, hrdata_bus, model_read(d, x.addr));
            else          model_write(d, x.addr, x.size, x.wdata);
            m_xfer[d]++;
        end
    endtask

    // Pipelined master: address of transfer n overlaps the data phase of n-1.
    task automatic run(input int d);
        int   a_i = 0, d_i = -1, stall = 0, cycles = 0;
        logic stall_resp = 1'b0;
        logic rdy;
        bit   done = 1'b0;
        sel = (d == 1);
        drive_addr(d, a_i);
        while (!done) begin
            @(negedge HCLK);
            rdy = hready_bus;
            if (d_i >= 0) begin
                if (!rdy) begin
                    stall++;
                    stall_resp = stall_resp | hresp_bus;
                end else begin
                    complete(d, d_i, stall, stall_resp);
                    stall = 0;
                    stall_resp = 1'b0;
                end
            end
            @(posedge HCLK);
            #1;
            if (rdy) begin
                if (a_i < xq.size()) begin
                    d_i = a_i;
                    a_i++;
                    HWDATA = xq[d_i].wdata;
                end else begin
                    d_i = -1;
                    done = 1'b1;
                    HWDATA = $urandom();
                end
                drive_addr(d, a_i);
            end
            cycles++;
            if (cycles > 200) begin
                n_vec++;
                n_bad++;
                $error("FAIL run_timeout dut=%0d observed=%0d cycles expected<=200", d, cycles);
                done = 1'b1;
            end
        end
        xq.delete();
    endtask

    task automatic readback(input int d);
        for (int k = 0; k < 8; k++) push(12'(k * 4), 1'b0, 3'd2, 32'h0, 1'b0);
        run(d);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; sel = 1'b0;
        HRESETn = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; HTRANS = 2'b00; HADDR = 32'h0;
        HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = 32'h0; HBURST = 3'd0; HPROT = 4'd0;
        HMASTLOCK = 1'b0;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        check("rst rdy0", {31'd0, rdy0}, 32'd1);
        check("rst rdy2", {31'd0, rdy2}, 32'd1);
        check("rst resp0", {31'd0, resp0}, 32'd0);
        check("rst resp2", {31'd0, resp2}, 32'd0);
        check("rst rdata0", rdata0, 32'h0);
        check("rst rdata2", rdata2, 32'h0);
        check("rst reg_out0", rout0, RV0);
        check("rst reg_out2", rout2, RV2);

        push(12'h004, 1'b1, 3'd2, 32'h1234_5678, 1'b0);
        push(12'h004, 1'b0, 3'd2, 32'h0, 1'b0);
        push(12'h01C, 1'b0, 3'd2, 32'h0, 1'b0);
        run(0);

        push(12'h000, 1'b1, 3'd2, 32'h0, 1'b0);
        push(12'h001, 1'b1, 3'd0, 32'h11AB_2233, 1'b0);
        run(0);
        check("byte lane reg_out", rout0, 32'h00AB_0000);
        push(12'h002, 1'b1, 3'd1, 32'h4455_CDEF, 1'b0);
        run(0);
        check("half lane reg_out", rout0, 32'h00AB_CDEF);

        push(12'h040, 1'b1, 3'd2, $urandom(), 1'b0);
        push(12'h01C, 1'b1, 3'd2, $urandom(), 1'b0);
        push(12'h01C, 1'b0, 3'd2, 32'h0, 1'b0);
        run(0);
        readback(0);

        push(12'h008, 1'b0, 3'd2, 32'h0, 1'b0);
        run(1);
        push(12'h00C, 1'b1, 3'd2, 32'hA5A5_5A5A, 1'b0);
        push(12'h00C, 1'b0, 3'd2, 32'h0, 1'b0);
        run(1);

        for (int d = 0; d < 2; d++) begin
            push(12'h018, 1'b0, 3'd2, 32'h0, 1'b0);
            push(12'h01C, 1'b0, 3'd2, 32'h0, 1'b1);
            push(12'h010, 1'b0, 3'd2, 32'h0, 1'b1);
            push(12'h014, 1'b0, 3'd2, 32'h0, 1'b1);
            run(d);
        end

        for (int r = 0; r < 16; r++) begin
            int n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                logic [11:0] a;
                logic [2:0]  s;
                if ($urandom_range(0, 9) < 8) a = 12'($urandom_range(0, 31));
                else                          a = 12'($urandom_range(32, 4095));
                if ($urandom_range(0, 9) < 9) s = 3'($urandom_range(0, 2));
                else                          s = 3'($urandom_range(3, 7));
                push(a, 1'($urandom()), s, $urandom(), (j > 0) ? 1'($urandom()) : 1'b0);
            end
            run(r % 2);
        end
        readback(0);
        readback(1);

        push(12'h000, 1'b1, 3'd2, 32'h0F0F_0F0F, 1'b0);
        run(1);
        sel = 1'b1; hsel0 = 1'b0; hsel2 = 1'b1; HTRANS = 2'b10; HADDR = 32'h0;
        HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        check("abort in wait", {31'd0, rdy2}, 32'd0);
        HWDATA = 32'h1111_1111; HTRANS = 2'b00; hsel2 = 1'b0; HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        model_reset();
        check("abort reg_out2", rout2, RV2);
        check("abort reg_out0", rout0, RV0);
        check("abort rdy2", {31'd0, rdy2}, 32'd1);
        push(12'h01C, 1'b0, 3'd2, 32'h0, 1'b0);
        run(1);
        readback(1);
        readback(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_regs.md
AHB_LITE_REGS -- requirements
Module: ahb_lite_regs

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, meaning data-phase wait cycles per OKAY transfer (legal 0..3).
REQ-002 SHALL have parameter RESET_VAL, default 32'h0000_0000, meaning the reset value of REG0..REG6.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port HRESETn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port HSEL, input, 1 bit: slave select.
REQ-006 SHALL have port HADDR, input, 32 bits: address; bits [11:0] are decoded.
REQ-007 SHALL have port HTRANS, input, 2 bits: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL have port HWRITE, input, 1 bit: 1 means write.
REQ-009 SHALL have port HSIZE, input, 3 bits: 000 byte, 001 halfword, 010 word.
REQ-010 SHALL have ports HBURST (input, 3 bits), HPROT (input, 4 bits) and HMASTLOCK (input, 1 bit); all are accepted and ignored.
REQ-011 SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-012 SHALL have port HREADY, input, 1 bit: bus-level ready; an address phase is sampled only when it is high.
REQ-013 SHALL have port HREADYOUT, output, 1 bit: slave ready.
REQ-014 SHALL have port HRESP, output, 1 bit: 0 OKAY, 1 ERROR.
REQ-015 SHALL have port HRDATA, output, 32 bits: read data.
REQ-016 SHALL have port reg_out, output, 32 bits: continuous copy of REG0, for driving the board GPIO.

Function
REQ-017 SHALL capture an address phase (address, write, size) when HSEL, HREADY and HTRANS[1] are all high at a clock edge.
REQ-018 SHALL answer IDLE, BUSY and unselected cycles with zero-wait OKAY and SHALL leave all state unchanged.
REQ-019 SHALL implement the FSM states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-020 SHALL take a valid capture to WAIT when WAIT_STATES>0, or to DATA when WAIT_STATES=0.
REQ-021 SHALL hold WAIT for WAIT_STATES cycles with HREADYOUT=0, then enter DATA.
REQ-022 SHALL drive HREADYOUT=1 and HRESP=0 in DATA; a new capture in DATA SHALL chain directly to the next phase, giving back-to-back transfers with no idle cycle.
REQ-023 SHALL map REG0..REG7 at word offsets 0x00..0x1C; REG0..REG6 are read/write, and REG7 is a read-only STATUS register.
REQ-024 SHALL define STATUS as {err_cnt[15:0], xfer_cnt[15:0]}.
REQ-025 SHALL increment xfer_cnt on every completed OKAY transfer and err_cnt on every ERROR response; both counters wrap modulo 2^16.
REQ-026 SHALL give an ERROR response for offset >= 0x20, for HSIZE > 010, for a misaligned halfword or word, and for a write to REG7.
REQ-027 SHALL sequence an ERROR as ERR1 (HREADYOUT=0, HRESP=1) followed by ERR2 (HREADYOUT=1, HRESP=1); no wait states are inserted on errors.
REQ-028 SHALL NOT modify any register on an erroring write.
REQ-029 SHALL ignore a capture attempted during ERR1; a capture during ERR2 SHALL be accepted.
REQ-030 SHALL commit a write at the clock edge that ends DATA, using HWDATA byte lanes in big-endian order: byte offset 0 maps to HWDATA[31:24], offset 3 to [7:0], halfword offset 0 to [31:16].
REQ-031 SHALL return HRDATA combinationally from the captured word offset while in DATA, with the full word driven regardless of HSIZE.
REQ-032 SHALL drive HRDATA = 0 in every state other than DATA.
REQ-033 SHALL return a read immediately following a write to the same register with the new value, with no hazard stall.
REQ-034 SHALL, when both counters change in the same cycle, apply both updates.

Reset
REQ-035 SHALL, while HRESETn=0 at an edge, set the FSM to IDLE, REG0..REG6 to RESET_VAL and both counters to 0.
REQ-036 SHALL drive HREADYOUT=1, HRESP=0, HRDATA=0 and reg_out=RESET_VAL after reset.
REQ-037 SHALL abort any in-flight transfer when reset is asserted mid-transfer; the aborted transfer SHALL NOT commit and SHALL NOT increment either counter.

Structure
REQ-038 SHALL place the HTRANS/HSIZE encodings, the register offsets and the FSM state enumeration in a shared package, ahb_lite_pkg, which the core bus slave also uses.
REQ-039 SHALL contain one sub-module, ahb_lite_bytelane, mapping {HSIZE, HADDR[1:0], HWDATA, old word} to the merged word.

Verification
REQ-040 SHALL be covered by: WAIT_STATES=0; word write 0x12345678 to 0x04, then read 0x04 -> HRDATA=0x12345678 in the first data cycle; STATUS reads 0x0000_0002.
REQ-041 SHALL be covered by: byte write 0xAB to 0x01 after REG0=0 -> reg_out=0x00AB0000; halfword write 0xCDEF to 0x02 -> 0x00ABCDEF.
REQ-042 SHALL be covered by: WAIT_STATES=2; read 0x08 -> HREADYOUT is 0,0 then 1, with data valid on the third cycle.
REQ-043 SHALL be covered by: write to 0x40, then write to 0x1C -> two-cycle ERROR each time, no register change, err_cnt=2.
REQ-044 SHALL be covered by: a 4-beat wrapping SEQ burst starting at 0x18 (0x18, 0x1C, 0x10, 0x14) -> four consecutive OKAY data phases.
REQ-045 SHALL be covered by: HRESETn low during WAIT of a write to 0x00 -> reg_out=RESET_VAL and STATUS=0.
